led_blinker: RTL and testbench

LED_BLINKER -- requirements
Module: led_blinker

---
 rtl/led_blinker_pkg.sv | 18 +
 rtl/blink_prescaler.sv | 27 ++
 rtl/led_blinker.sv | 132 +++++++++++++
 tb/tb_led_blinker.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_blinker_pkg.sv
// led_blinker_pkg: shared types for the LED blinker.
// Holds FSM state encoding, phase width and a tick-limit helper.
package led_blinker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } state_e;

  localparam int PHASE_W = 8;

  // Phase counter value on the last tick of a phase lasting n ticks.
  function automatic logic [PHASE_W-1:0] last_tick(int unsigned n);
    return PHASE_W'(n - 1);
  endfunction

endpackage

// File: rtl/blink_prescaler.sv
// blink_prescaler: free-running DIV_BITS-bit divider.
// Ports: sysclk, rst (sync, high), clr (sync restart), tick (counter all ones).
module blink_prescaler #(
  parameter int DIV_BITS = 21
) (
  input  logic sysclk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  logic [DIV_BITS-1:0] cnt_q;
  logic [DIV_BITS-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q + DIV_BITS'(1);
    if (clr) cnt_d = '0;
  end

  always_ff @(posedge sysclk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign tick = &cnt_q;

endmodule

// File: rtl/led_blinker.sv
// led_blinker: queues blink requests and plays them as ON/OFF phases.
// Ports: sysclk, rst (sync, high), evt (request pulse), led, busy,
//   pending (queued blinks incl. current), ovf (only with
//   LED_BLINKER_OVERFLOW_EN: sticky flag for requests dropped at saturation).
module led_blinker
  import led_blinker_pkg::*;
#(
  parameter int DIV_BITS  = 21,
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 4,
  parameter int CNT_W     = 4
) (
  input  logic             sysclk,
  input  logic             rst,
  input  logic             evt,
  output logic             led,
  output logic             busy,
  output logic [CNT_W-1:0] pending
`ifdef LED_BLINKER_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam logic [PHASE_W-1:0] ON_LAST  = last_tick(ON_TICKS);
  localparam logic [PHASE_W-1:0] OFF_LAST = last_tick(OFF_TICKS);
  localparam logic [CNT_W-1:0]   PEND_MAX = '1;
  localparam logic [CNT_W-1:0]   PEND_ONE = CNT_W'(1);

  state_e               state_q, state_d;
  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]     pend_q, pend_d;
  logic                 tick;
  logic                 clr;
  logic                 on_end;
  logic                 off_end;
  logic                 active;

  blink_prescaler #(
    .DIV_BITS(DIV_BITS)
  ) u_presc (
    .sysclk(sysclk),
    .rst   (rst),
    .clr   (clr),
    .tick  (tick)
  );

  assign active  = (state_q != IDLE);
  assign clr     = (state_q == IDLE) && evt;
  assign on_end  = (state_q == ON) && tick && (phase_q == ON_LAST);
  assign off_end = (state_q == OFF) && tick && (phase_q == OFF_LAST);

  always_ff @(posedge sysclk) begin
    if (rst) begin
      state_q <= IDLE;
      phase_q <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pend_q  <= pend_d;
    end
  end

  // An evt landing on the end of OFF replaces the decrement,
  // so the queue stays nonempty and another blink follows.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (evt) state_d = ON;
      ON:   if (on_end) state_d = OFF;
      OFF: begin
        if (off_end)
          state_d = (evt || pend_q != PEND_ONE) ? ON : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    phase_d = phase_q;
    pend_d  = pend_q;
    unique case (state_q)
      IDLE: begin
        if (evt) begin
          phase_d = '0;
          pend_d  = PEND_ONE;
        end
      end
      ON: begin
        if (tick)
          phase_d = on_end ? '0 : phase_q + PHASE_W'(1);
        if (evt && pend_q != PEND_MAX)
          pend_d = pend_q + CNT_W'(1);
      end
      OFF: begin
        if (tick)
          phase_d = off_end ? '0 : phase_q + PHASE_W'(1);
        if (off_end) begin
          if (!evt) pend_d = pend_q - CNT_W'(1);
        end else if (evt && pend_q != PEND_MAX) begin
          pend_d = pend_q + CNT_W'(1);
        end
      end
      default: begin
        phase_d = '0;
        pend_d  = '0;
      end
    endcase
  end

  always_comb begin
    led     = (state_q == ON);
    busy    = active;
    pending = pend_q;
  end

`ifdef LED_BLINKER_OVERFLOW_EN
  logic ovf_q;
  logic ovf_set;

  assign ovf_set = active && evt && !off_end && (pend_q == PEND_MAX);

  always_ff @(posedge sysclk) begin
    if (rst)          ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_led_blinker.sv
// tb_led_blinker: directed checks of led_blinker timing and queueing.
// Two instances share stimulus: CNT_W=4 (a) and CNT_W=2 (b).
module tb_led_blinker;

  localparam int DB = 2;
  localparam int ONT = 2;
  localparam int OFFT = 1;

  logic       sysclk;
  logic       rst;
  logic       evt;
  logic       led_a, busy_a;
  logic [3:0] pend_a;
  logic       led_b, busy_b;
  logic [1:0] pend_b;
`ifdef LED_BLINKER_OVERFLOW_EN
  logic       ovf_a, ovf_b;
`endif

  int n_chk;
  int n_fail;

  led_blinker #(
    .DIV_BITS(DB), .ON_TICKS(ONT), .OFF_TICKS(OFFT), .CNT_W(4)
  ) dut_a (
    .sysclk (sysclk),
    .rst    (rst),
    .evt    (evt),
    .led    (led_a),
    .busy   (busy_a),
    .pending(pend_a)
`ifdef LED_BLINKER_OVERFLOW_EN
    ,
    .ovf    (ovf_a)
`endif
  );

  led_blinker #(
    .DIV_BITS(DB), .ON_TICKS(ONT), .OFF_TICKS(OFFT), .CNT_W(2)
  ) dut_b (
    .sysclk (sysclk),
    .rst    (rst),
    .evt    (evt),
    .led    (led_b),
    .busy   (busy_b),
    .pending(pend_b)
`ifdef LED_BLINKER_OVERFLOW_EN
    ,
    .ovf    (ovf_b)
`endif
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  task automatic do_reset();
    @(negedge sysclk);
    rst = 1'b1;
    evt = 1'b0;
    @(negedge sysclk);
    @(negedge sysclk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge sysclk);
    n_chk++;
    if ({led_a, busy_a, pend_a} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_a: got led=%b busy=%b pend=%0d, need 0",
               led_a, busy_a, pend_a);
    end
    n_chk++;
    if ({led_b, busy_b, pend_b} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_b: got led=%b busy=%b pend=%0d, need 0",
               led_b, busy_b, pend_b);
    end
`ifdef LED_BLINKER_OVERFLOW_EN
    n_chk++;
    if ({ovf_a, ovf_b} !== 2'b0) begin
      n_fail++;
      $display("FAIL reset_ovf: got %b%b, need 00", ovf_a, ovf_b);
    end
`endif
  endtask

  task automatic test_single();
    logic el, eb;
    logic [3:0] ep;
    do_reset();
    for (int c = 0; c < 26; c++) begin
      @(negedge sysclk);
      el = (c >= 11 && c <= 18);
      eb = (c >= 11 && c <= 22);
      ep = eb ? 4'd1 : 4'd0;
      n_chk++;
      if (led_a !== el || busy_a !== eb || pend_a !== ep) begin
        n_fail++;
        $display("FAIL single c%0d: got %b/%b/%0d, need %b/%b/%0d",
                 c, led_a, busy_a, pend_a, el, eb, ep);
      end
      evt = (c == 10);
    end
    evt = 1'b0;
  endtask

  task automatic test_three();
    logic el, eb;
    logic [3:0] ep;
    do_reset();
    for (int c = 0; c < 50; c++) begin
      @(negedge sysclk);
      el = (c >= 11 && c <= 18) || (c >= 23 && c <= 30) ||
           (c >= 35 && c <= 42);
      eb = (c >= 11 && c <= 46);
      if (c < 11)      ep = 4'd0;
      else if (c < 13) ep = 4'd1;
      else if (c < 15) ep = 4'd2;
      else if (c < 23) ep = 4'd3;
      else if (c < 35) ep = 4'd2;
      else if (c < 47) ep = 4'd1;
      else             ep = 4'd0;
      n_chk++;
      if (led_a !== el || busy_a !== eb || pend_a !== ep) begin
        n_fail++;
        $display("FAIL three c%0d: got %b/%b/%0d, need %b/%b/%0d",
                 c, led_a, busy_a, pend_a, el, eb, ep);
      end
      evt = (c == 10 || c == 12 || c == 14);
    end
    evt = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic el, eb;
    logic [3:0] ep;
    do_reset();
    for (int c = 0; c < 38; c++) begin
      @(negedge sysclk);
      el = (c >= 11 && c <= 18) || (c >= 23 && c <= 30);
      eb = (c >= 11 && c <= 34);
      ep = eb ? 4'd1 : 4'd0;
      n_chk++;
      if (led_a !== el || busy_a !== eb || pend_a !== ep) begin
        n_fail++;
        $display("FAIL b2b c%0d: got %b/%b/%0d, need %b/%b/%0d",
                 c, led_a, busy_a, pend_a, el, eb, ep);
      end
      evt = (c == 10 || c == 22);
    end
    evt = 1'b0;
  endtask

  task automatic test_saturate();
    logic eb;
    logic [1:0] ep;
    do_reset();
    for (int c = 0; c < 52; c++) begin
      @(negedge sysclk);
      eb = (c >= 11 && c <= 46);
      if (c < 11)      ep = 2'd0;
      else if (c < 13) ep = 2'(c - 10);
      else if (c < 23) ep = 2'd3;
      else if (c < 35) ep = 2'd2;
      else if (c < 47) ep = 2'd1;
      else             ep = 2'd0;
      n_chk++;
      if (busy_b !== eb || pend_b !== ep) begin
        n_fail++;
        $display("FAIL sat c%0d: got busy=%b pend=%0d, need %b/%0d",
                 c, busy_b, pend_b, eb, ep);
      end
`ifdef LED_BLINKER_OVERFLOW_EN
      n_chk++;
      if (ovf_b !== (c >= 14)) begin
        n_fail++;
        $display("FAIL sat_ovf c%0d: got %b, need %b", c, ovf_b, c >= 14);
      end
`endif
      if (c == 16) begin
        n_chk++;
        if (pend_a !== 4'd6) begin
          n_fail++;
          $display("FAIL sat_a_pend: got %0d, need 6", pend_a);
        end
      end
      evt = (c >= 10 && c <= 15);
    end
    evt = 1'b0;
    rst = 1'b1;
    @(negedge sysclk);
    rst = 1'b0;
    n_chk++;
    if (busy_b !== 1'b0 || pend_b !== 2'd0) begin
      n_fail++;
      $display("FAIL sat_rst: got busy=%b pend=%0d, need 0/0",
               busy_b, pend_b);
    end
`ifdef LED_BLINKER_OVERFLOW_EN
    n_chk++;
    if (ovf_b !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_ovf_clr: got %b, need 0", ovf_b);
    end
`endif
  endtask

  task automatic test_rst_mid_on();
    logic el, eb;
    logic [3:0] ep;
    do_reset();
    for (int c = 0; c < 36; c++) begin
      @(negedge sysclk);
      el = (c >= 11 && c <= 14) || (c >= 21 && c <= 28);
      eb = (c >= 11 && c <= 14) || (c >= 21 && c <= 32);
      ep = eb ? 4'd1 : 4'd0;
      n_chk++;
      if (led_a !== el || busy_a !== eb || pend_a !== ep) begin
        n_fail++;
        $display("FAIL rst_on c%0d: got %b/%b/%0d, need %b/%b/%0d",
                 c, led_a, busy_a, pend_a, el, eb, ep);
      end
      evt = (c == 10 || c == 20);
      rst = (c == 14);
    end
    evt = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_rst_evt();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge sysclk);
      if (c >= 11) begin
        n_chk++;
        if (led_a !== 1'b0 || busy_a !== 1'b0 || pend_a !== 4'd0) begin
          n_fail++;
          $display("FAIL rst_evt c%0d: got %b/%b/%0d, need 0/0/0",
                   c, led_a, busy_a, pend_a);
        end
      end
      evt = (c == 10);
      rst = (c == 10);
    end
    evt = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b1;
    evt    = 1'b0;
    test_reset();
    test_single();
    test_three();
    test_back_to_back();
    test_saturate();
    test_rst_mid_on();
    test_rst_evt();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
